neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

Sequential floating-point accumulator sitting directly downstream of the 6-bit mantissa multiplier in the neuron datapath. Accepts a stream of products (sign, 7-bit exponent, 12-bit mantissa) over a valid/ready handshake and sums them with a multi-cycle align/add/normalize state machine. On the term flagged last, it emits the neuron's weighted sum repacked into the operand format: sign, 5-bit exponent, 6-bit mantissa.

## Interface
- Parameters: none. Widths are fixed by the multiplier format.
- Clk  in  1  single clock; all state updates on rising edge
- ResetN  in  1  synchronous, active-low reset
- PSign  in  1  product sign (1 = negative)
- PExponent  in  6  product exponent, low bits
- PExponentC  in  1  product exponent carry; full exponent PE = {PExponentC, PExponent}, unsigned 0..127
- PMantissa  in  12  product mantissa, unsigned; value = (-1)^PSign × PMantissa × 2^PE
- PLast  in  1  marks final term of the current sum
- PValid  in  1  product present
- PReady  out  1  high only in IDLE
- SumSign  out  1  result sign
- SumExponent  out  5  result exponent
- SumMantissa  out  6  result mantissa
- SumOverflow  out  1  result saturated
- SumValid  out  1  result present
- SumReady  in  1  consumer accepts result

## Operation
- Internal state:
  - A: 18-bit signed accumulator mantissa.
  - AE: 8-bit unsigned exponent.
  - B / BE: captured product, sign-applied to 18-bit signed.
  - Empty flag and Last flag.
- IDLE: PReady=1. On PValid&PReady, capture the product and PLast.
  - If Empty: A<=B, AE<=BE, Empty<=0. Next state is NORM if last, else IDLE.
  - Otherwise go to ALIGN.
- ALIGN: one step per cycle until AE==BE.
  - The operand with the smaller exponent is arithmetic-shifted right 1 bit and its exponent is incremented. Truncation only, no rounding.
  - If the exponent difference is ≥18, the smaller operand becomes 0 and its exponent is set equal to the other's, in a single cycle.
  - When AE==BE (including on entry), go to ADD.
- ADD: compute the 19-bit signed sum A+B.
  - If the sum does not fit in 18-bit signed: A<=sum>>>1, AE<=AE+1.
  - Otherwise: A<=sum.
  - Next state is NORM if Last, else IDLE.
- NORM: operates on magnitude M=|A| and exponent E=AE, one step per cycle.
  - M==0: the result is forced to sign 0, exponent 0, mantissa 0, in one cycle.
  - M≥64: M>>=1 (truncate), E+=1.
  - 0<M<32 and E>0: M<<=1, E-=1.
  - Otherwise done: go to OUT. SumSign=(A<0). If E>31, saturate to SumExponent=31, SumMantissa=63, SumOverflow=1.
- OUT: SumValid=1; all Sum* outputs stay stable until SumReady.
  - On SumValid&SumReady: Empty<=1, go to IDLE.
- AE never wraps. Its 8-bit width covers 127 plus the normalization and ADD increments.

## Timing
- Reset, synchronous and active-low on a Clk edge with ResetN=0: state=IDLE, PReady=1, SumValid=0, SumSign/SumExponent/SumMantissa/SumOverflow=0, A=0, AE=0, Empty=1, Last=0.
- Reset overrides any state mid-operation. A partial sum is discarded, and a pending output is dropped without handshake.
- PReady is combinational from state and is 0 in ALIGN, ADD, NORM and OUT.
- Cycle counts:
  - Accept cycle: 1.
  - ALIGN: min(|AE−BE|, 1 if difference ≥18) cycles.
  - ADD: 1.
  - NORM: number of shift steps + 1.
  - SumValid rises the cycle after NORM completes.
- Single-term sum (Empty and PLast): accept, NORM, OUT. No ALIGN or ADD.
- Back-to-back terms: the next PValid can be accepted the cycle after ADD, when the state has returned to IDLE.
- PValid in OUT is ignored. It is not captured until IDLE.
- SumValid with SumReady=0 holds indefinitely with no output change.

## Test plan
- Reset then single product: PSign=1, PE=9, PMantissa=63, PLast=1 → SumSign=1, SumExponent=9, SumMantissa=63, SumOverflow=0. SumValid rises 3 cycles after acceptance (accept, NORM done, OUT).
- Cancellation: +63·2^9, then −63·2^9 with PLast → output 0/0/0, SumOverflow=0.
- Alignment plus left normalization: +12·2^2, then +3·2^4 with PLast → 2 ALIGN cycles, 3 left shifts. Output sign 0, exponent 1, mantissa 48 (value 96).
- Large exponent gap: +1·2^0, then +100·2^20 with PLast → single-cycle flush in ALIGN. Output sign 0, exponent 21, mantissa 50.
- Saturation: PMantissa=4095, PE=127, PLast=1 → SumExponent=31, SumMantissa=63, SumOverflow=1.
- Backpressure and reset: hold SumReady=0 for 10 cycles.
  - Required: outputs stable, PReady=0, extra PValid ignored.
  - Then assert ResetN=0 mid-OUT: next edge gives SumValid=0, PReady=1, all outputs 0.

Source files
------------

// File: rtl/neuron_accumulator_if.sv
// Product-in / weighted-sum-out bus of the neuron accumulator.
// The accumulator is the slave; the upstream multiplier and downstream consumer form the master.
interface neuron_accumulator_if;
    logic        PSign;
    logic [5:0]  PExponent;
    logic        PExponentC;
    logic [11:0] PMantissa;
    logic        PLast;
    logic        PValid;
    logic        PReady;
    logic        SumSign;
    logic [4:0]  SumExponent;
    logic [5:0]  SumMantissa;
    logic        SumOverflow;
    logic        SumValid;
    logic        SumReady;

    modport master (
        output PSign, PExponent, PExponentC, PMantissa, PLast, PValid, SumReady,
        input  PReady, SumSign, SumExponent, SumMantissa, SumOverflow, SumValid
    );
    modport slave (
        input  PSign, PExponent, PExponentC, PMantissa, PLast, PValid, SumReady,
        output PReady, SumSign, SumExponent, SumMantissa, SumOverflow, SumValid
    );
endinterface

// File: rtl/neuron_accumulator.sv
// Sequential floating-point accumulator: aligns, adds and normalizes a stream of
// 12-bit-mantissa products, emitting a 1/5/6 sign/exponent/mantissa sum on the last term.
module neuron_accumulator (
    input  logic                  Clk,
    input  logic                  ResetN,
    neuron_accumulator_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    state_t             state, stateNext;
    logic signed [17:0] accMant, bMant;
    logic [7:0]         accExp, bExp;
    logic               isEmpty, isLast;
    logic [17:0]        normMag;
    logic               sumSign, sumOvf;
    logic [4:0]         sumExp;
    logic [5:0]         sumMant;

    logic signed [17:0] pMant, addMant;
    logic [17:0]        pMag, addMag;
    logic [7:0]         pExp, expDiff;
    logic               accSmaller, addCarry, flush;
    logic signed [18:0] sumFull;

    assign pMag       = {6'd0, bus.PMantissa};
    assign pMant      = bus.PSign ? -$signed(pMag) : $signed(pMag);
    assign pExp       = {1'b0, bus.PExponentC, bus.PExponent};
    assign accSmaller = accExp < bExp;
    assign expDiff    = accSmaller ? bExp - accExp : accExp - bExp;
    assign flush      = expDiff >= 8'd18;
    assign sumFull    = {accMant[17], accMant} + {bMant[17], bMant};
    // Sign bit disagreeing with bit 17 means the sum left the 18-bit signed range.
    assign addCarry   = sumFull[18] ^ sumFull[17];
    assign addMant    = addCarry ? sumFull[18:1] : sumFull[17:0];
    assign addMag     = addMant[17] ? 18'(-addMant) : 18'(addMant);

    assign bus.PReady      = (state == IDLE);
    assign bus.SumValid    = (state == OUT);
    assign bus.SumSign     = sumSign;
    assign bus.SumExponent = sumExp;
    assign bus.SumMantissa = sumMant;
    assign bus.SumOverflow = sumOvf;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (bus.PValid) begin
                if (isEmpty)             stateNext = bus.PLast ? NORM : IDLE;
                else if (pExp == accExp) stateNext = ADD;
                else                     stateNext = ALIGN;
            end
            ALIGN: if (flush || expDiff <= 8'd1) stateNext = ADD;
            ADD:   stateNext = isLast ? NORM : IDLE;
            NORM: begin
                if (normMag == 18'd0)                         stateNext = OUT;
                else if (normMag >= 18'd64)                   stateNext = NORM;
                else if (normMag < 18'd32 && accExp != 8'd0)  stateNext = NORM;
                else                                          stateNext = OUT;
            end
            OUT:   if (bus.SumReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state   <= IDLE;
            accMant <= '0;
            accExp  <= '0;
            bMant   <= '0;
            bExp    <= '0;
            isEmpty <= 1'b1;
            isLast  <= 1'b0;
            normMag <= '0;
            sumSign <= 1'b0;
            sumExp  <= '0;
            sumMant <= '0;
            sumOvf  <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (bus.PValid) begin
                    bMant  <= pMant;
                    bExp   <= pExp;
                    isLast <= bus.PLast;
                    if (isEmpty) begin
                        accMant <= pMant;
                        accExp  <= pExp;
                        isEmpty <= 1'b0;
                        normMag <= pMag;
                    end
                end
                ALIGN: begin
                    // Only the smaller-exponent operand moves; a gap of 18+ flushes it in one step.
                    if (accSmaller) begin
                        accMant <= flush ? 18'sd0 : accMant >>> 1;
                        accExp  <= flush ? bExp : accExp + 8'd1;
                    end else begin
                        bMant <= flush ? 18'sd0 : bMant >>> 1;
                        bExp  <= flush ? accExp : bExp + 8'd1;
                    end
                end
                ADD: begin
                    accMant <= addMant;
                    accExp  <= accExp + {7'd0, addCarry};
                    normMag <= addMag;
                end
                NORM: begin
                    if (normMag == 18'd0) begin
                        sumSign <= 1'b0;
                        sumExp  <= '0;
                        sumMant <= '0;
                        sumOvf  <= 1'b0;
                    end else if (normMag >= 18'd64) begin
                        normMag <= normMag >> 1;
                        accExp  <= accExp + 8'd1;
                    end else if (normMag < 18'd32 && accExp != 8'd0) begin
                        normMag <= normMag << 1;
                        accExp  <= accExp - 8'd1;
                    end else begin
                        sumSign <= accMant[17];
                        if (accExp > 8'd31) begin
                            sumExp  <= 5'd31;
                            sumMant <= 6'd63;
                            sumOvf  <= 1'b1;
                        end else begin
                            sumExp  <= accExp[4:0];
                            sumMant <= normMag[5:0];
                            sumOvf  <= 1'b0;
                        end
                    end
                end
                OUT: if (bus.SumReady) isEmpty <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench: directed corner cases plus randomized sums against an arithmetic model.
module tb_neuron_accumulator;
    logic Clk = 1'b0;
    logic ResetN = 1'b0;
    int   nCmp = 0;
    int   nBad = 0;
    int   qS[64];
    int   qE[64];
    int   qM[64];

    neuron_accumulator_if bus();
    neuron_accumulator dut (.Clk(Clk), .ResetN(ResetN), .bus(bus.slave));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nCmp++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Reference: bulk align with floor shifts, 18-bit signed add, then normalize magnitude.
    function automatic void model(input int n, output bit s, output int e, output int m, output bit o);
        longint a, b, mag;
        int ae, be, d;
        a  = qS[0] ? -longint'(qM[0]) : longint'(qM[0]);
        ae = qE[0];
        for (int i = 1; i < n; i++) begin
            b  = qS[i] ? -longint'(qM[i]) : longint'(qM[i]);
            be = qE[i];
            d  = (ae > be) ? ae - be : be - ae;
            if (ae < be) begin
                a  = (d >= 18) ? 0 : (a >>> d);
                ae = be;
            end else if (be < ae) begin
                b = (d >= 18) ? 0 : (b >>> d);
            end
            a = a + b;
            if (a > 131071 || a < -131072) begin
                a = a >>> 1;
                ae++;
            end
        end
        mag = (a < 0) ? -a : a;
        s = 0; e = 0; m = 0; o = 0;
        if (mag != 0) begin
            while (mag >= 64) begin mag = mag >> 1; ae++; end
            while (mag < 32 && ae > 0) begin mag = mag << 1; ae--; end
            s = (a < 0);
            if (ae > 31) begin e = 31; m = 63; o = 1; end
            else begin e = ae; m = int'(mag); end
        end
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic sendTerm(input bit s, input int e, input int m, input bit last);
        int n = 0;
        while (!bus.PReady && n < 600) begin @(negedge Clk); n++; end
        if (n >= 600) chk("readyTimeout", {31'd0, bus.PReady}, 32'd1);
        bus.PSign      = s;
        bus.PExponent  = e[5:0];
        bus.PExponentC = e[6];
        bus.PMantissa  = m[11:0];
        bus.PLast      = last;
        bus.PValid     = 1'b1;
        @(negedge Clk);
        bus.PValid     = 1'b0;
    endtask

    // lat counts cycles with the accept cycle as 1; expLat<=0 skips the latency check.
    task automatic expectResult(input string tag, input bit es, input int ee, input int em, input bit eo,
                                input int hold, input int expLat, input bit junk, input bit ack);
        int lat = 2;
        while (!bus.SumValid && lat < 600) begin @(negedge Clk); lat++; end
        chk({tag, ".valid"}, {31'd0, bus.SumValid}, 32'd1);
        if (expLat > 0) chk({tag, ".lat"}, lat, expLat);
        if (junk) begin
            bus.PSign = 1'b1; bus.PExponent = 6'h3f; bus.PExponentC = 1'b1;
            bus.PMantissa = 12'hfff; bus.PLast = 1'b1; bus.PValid = 1'b1;
        end
        for (int h = 0; h <= hold; h++) begin
            chk({tag, ".sign"}, {31'd0, bus.SumSign}, {31'd0, es});
            chk({tag, ".exp"},  {27'd0, bus.SumExponent}, ee);
            chk({tag, ".mant"}, {26'd0, bus.SumMantissa}, em);
            chk({tag, ".ovf"},  {31'd0, bus.SumOverflow}, {31'd0, eo});
            if (junk) chk({tag, ".preadyOut"}, {31'd0, bus.PReady}, 32'd0);
            if (h > 0) chk({tag, ".hold"}, {31'd0, bus.SumValid}, 32'd1);
            if (h < hold) @(negedge Clk);
        end
        if (ack) begin
            bus.SumReady = 1'b1;
            @(negedge Clk);
            bus.SumReady = 1'b0;
            bus.PValid   = 1'b0;
        end
    endtask

    initial begin
        bit s, o;
        int e, m, n, base;
        bus.PSign = 0; bus.PExponent = 0; bus.PExponentC = 0; bus.PMantissa = 0;
        bus.PLast = 0; bus.PValid = 0; bus.SumReady = 0;
        repeat (2) @(negedge Clk);
        chk("rst.valid", {31'd0, bus.SumValid}, 32'd0);
        chk("rst.ready", {31'd0, bus.PReady}, 32'd1);
        chk("rst.sign",  {31'd0, bus.SumSign}, 32'd0);
        chk("rst.exp",   {27'd0, bus.SumExponent}, 32'd0);
        chk("rst.mant",  {26'd0, bus.SumMantissa}, 32'd0);
        chk("rst.ovf",   {31'd0, bus.SumOverflow}, 32'd0);
        ResetN = 1'b1;
        @(negedge Clk);

        sendTerm(1, 9, 63, 1);
        expectResult("single", 1, 9, 63, 0, 1, 3, 0, 1);

        sendTerm(0, 9, 63, 0);
        sendTerm(1, 9, 63, 1);
        expectResult("cancel", 0, 0, 0, 0, 0, -1, 0, 1);

        sendTerm(0, 2, 12, 0);
        sendTerm(0, 4, 3, 1);
        chk("align.pready", {31'd0, bus.PReady}, 32'd0);
        expectResult("align", 0, 1, 48, 0, 0, 9, 0, 1);

        sendTerm(0, 0, 1, 0);
        sendTerm(0, 20, 100, 1);
        expectResult("gap", 0, 21, 50, 0, 0, 6, 0, 1);

        sendTerm(0, 127, 4095, 1);
        expectResult("sat", 0, 31, 63, 1, 0, -1, 0, 1);

        // Backpressure with junk offered in OUT, then reset while the result is pending.
        sendTerm(1, 9, 63, 1);
        expectResult("bp", 1, 9, 63, 0, 10, 3, 1, 0);
        ResetN = 1'b0;
        bus.PValid = 1'b0;
        @(negedge Clk);
        chk("rst2.valid", {31'd0, bus.SumValid}, 32'd0);
        chk("rst2.ready", {31'd0, bus.PReady}, 32'd1);
        chk("rst2.sign",  {31'd0, bus.SumSign}, 32'd0);
        chk("rst2.exp",   {27'd0, bus.SumExponent}, 32'd0);
        chk("rst2.mant",  {26'd0, bus.SumMantissa}, 32'd0);
        chk("rst2.ovf",   {31'd0, bus.SumOverflow}, 32'd0);
        ResetN = 1'b1;
        @(negedge Clk);

        sendTerm(0, 3, 40, 1);
        expectResult("junk", 0, 3, 40, 0, 3, -1, 1, 1);
        chk("junk.idle", {31'd0, bus.PReady}, 32'd1);
        sendTerm(0, 1, 5, 1);
        expectResult("denorm", 0, 0, 10, 0, 0, -1, 0, 1);

        // Enough full-scale terms at one exponent to overflow the 18-bit adder.
        for (int i = 0; i < 40; i++) begin qS[i] = 0; qE[i] = 0; qM[i] = 4095; end
        model(40, s, e, m, o);
        for (int i = 0; i < 40; i++) sendTerm(0, 0, 4095, i == 39);
        expectResult("long", s, e, m, o, 0, -1, 0, 1);

        for (int t = 0; t < 60; t++) begin
            n    = $urandom_range(1, 5);
            base = $urandom_range(0, 110);
            for (int i = 0; i < n; i++) begin
                qS[i] = $urandom_range(0, 1);
                qE[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : base + $urandom_range(0, 17);
                qM[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 4095);
            end
            model(n, s, e, m, o);
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge Clk);
                sendTerm(qS[i][0], qE[i], qM[i], i == n - 1);
            end
            expectResult("rnd", s, e, m, o, $urandom_range(0, 2), -1, 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
